// File: rtl/operand_stage_pkg.sv
// Shared CPU definitions for the operand stage: datapath widths, register
// index width, the decoded-control bundle layout and the x0 index.
package operand_stage_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 16;
  localparam int RW   = 4;

  // x0 reads as zero, is never written and never causes a hazard.
  localparam logic [RW-1:0] X0_IDX = '0;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  // Decoded-control bundle. This stage never looks inside it; the layout
  // lives here so decode and execute agree on it.
  typedef struct packed {
    alu_op_e    alu_op;
    logic [2:0] fu_sel;
    logic       use_imm;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       csr;
    logic [2:0] rsvd;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  // One-hot of a register index, gated by en. Bit 0 is always left clear so
  // x0 can never enter the scoreboard or the busy mask.
  function automatic logic [NREG-1:0] idx_onehot(input logic [RW-1:0] idx,
                                                 input logic          en);
    logic [NREG-1:0] m;
    m = '0;
    if (en && (idx != X0_IDX)) m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/operand_stage_hazard_scoreboard.sv
// Per-register scoreboard of in-flight destinations plus the RAW/WAW hazard
// compare for the instruction offered by decode.
module hazard_scoreboard
  import operand_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            set_en_i,
  input  logic [RW-1:0]   set_idx_i,
  input  logic            clr_en_i,
  input  logic [RW-1:0]   clr_idx_i,
  input  logic            held_en_i,
  input  logic [RW-1:0]   held_idx_i,
  input  logic [RW-1:0]   rs1_i,
  input  logic [RW-1:0]   rs2_i,
  input  logic [RW-1:0]   rd_i,
  input  logic            uses_rs1_i,
  input  logic            uses_rs2_i,
  input  logic            writes_rd_i,
  output logic            hazard_o,
  output logic [NREG-1:0] pending_o
);

  logic [NREG-1:0] pending_q, pending_d;
  logic [NREG-1:0] set_mask, clr_mask, held_mask, busy;

  assign set_mask  = idx_onehot(set_idx_i, set_en_i);
  assign clr_mask  = idx_onehot(clr_idx_i, clr_en_i);
  assign held_mask = idx_onehot(held_idx_i, held_en_i);

  // Next scoreboard: clear on writeback, then set on transfer so a set wins
  // over a clear of the same index in the same cycle.
  always_comb begin
    pending_d = (pending_q & ~clr_mask) | set_mask;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  // A returning writeback frees its register this cycle (the operand mux
  // forwards it); the instruction sitting in the output register is busy
  // even before execute takes it.
  always_comb begin
    busy     = (pending_q & ~clr_mask) | held_mask;
    hazard_o = (uses_rs1_i  && busy[rs1_i]) ||
               (uses_rs2_i  && busy[rs2_i]) ||
               (writes_rd_i && busy[rd_i]);
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/operand_stage.sv
// Operand-fetch / issue stage: reads the register file, forwards the
// same-cycle writeback, stalls on scoreboard hazards and holds one
// instruction toward execute.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready
// are both high; the offering side keeps its payload stable while valid is
// high and ready is low, and ready may depend combinationally on valid.
module operand_stage
  import operand_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [RW-1:0]     in_rs1,
  input  logic [RW-1:0]     in_rs2,
  input  logic [RW-1:0]     in_rd,
  input  logic              in_uses_rs1,
  input  logic              in_uses_rs2,
  input  logic              in_writes_rd,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic [RW-1:0]     rf_rs1,
  output logic [RW-1:0]     rf_rs2,
  input  logic [XLEN-1:0]   rf_rs1_val,
  input  logic [XLEN-1:0]   rf_rs2_val,
  input  logic              wb_valid,
  input  logic [RW-1:0]     wb_rd,
  input  logic [XLEN-1:0]   wb_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_rs1_val,
  output logic [XLEN-1:0]   out_rs2_val,
  output logic [XLEN-1:0]   out_imm,
  output logic [RW-1:0]     out_rd,
  output logic              out_writes_rd,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [NREG-1:0]   dbg_pending_o
);

  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   out_rs1_val_q, out_rs1_val_d;
  logic [XLEN-1:0]   out_rs2_val_q, out_rs2_val_d;
  logic [XLEN-1:0]   out_imm_q, out_imm_d;
  logic [RW-1:0]     out_rd_q, out_rd_d;
  logic              out_writes_rd_q, out_writes_rd_d;
  logic [CTRL_W-1:0] out_ctrl_q, out_ctrl_d;

  logic              hazard, accept, sb_set, sb_held;
  logic [XLEN-1:0]   rs1_sel, rs2_sel;

  // x0 reads zero; otherwise the writeback bypasses the register file's
  // one-cycle write latency.
  function automatic logic [XLEN-1:0] sel_operand(input logic [RW-1:0]   idx,
                                                  input logic [XLEN-1:0] rf_val,
                                                  input logic            wb_en,
                                                  input logic [RW-1:0]   wb_idx,
                                                  input logic [XLEN-1:0] wb_val);
    if (idx == X0_IDX)                  return '0;
    else if (wb_en && (wb_idx == idx))  return wb_val;
    else                                return rf_val;
  endfunction

  assign rf_rs1   = in_rs1;
  assign rf_rs2   = in_rs2;
  assign rs1_sel  = sel_operand(in_rs1, rf_rs1_val, wb_valid, wb_rd, wb_result);
  assign rs2_sel  = sel_operand(in_rs2, rf_rs2_val, wb_valid, wb_rd, wb_result);

  assign in_ready = rst_n && !flush && !hazard && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Execute took a register writer: it is now in flight. This holds even in
  // a flush cycle, because the transfer already happened.
  assign sb_set   = out_valid_q && out_ready && out_writes_rd_q && (out_rd_q != X0_IDX);
  assign sb_held  = out_valid_q && out_writes_rd_q;

  hazard_scoreboard u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .set_en_i    (sb_set),
    .set_idx_i   (out_rd_q),
    .clr_en_i    (wb_valid),
    .clr_idx_i   (wb_rd),
    .held_en_i   (sb_held),
    .held_idx_i  (out_rd_q),
    .rs1_i       (in_rs1),
    .rs2_i       (in_rs2),
    .rd_i        (in_rd),
    .uses_rs1_i  (in_uses_rs1),
    .uses_rs2_i  (in_uses_rs2),
    .writes_rd_i (in_writes_rd),
    .hazard_o    (hazard),
    .pending_o   (dbg_pending_o)
  );

  // Output register next state: payload loads only on accept; valid drops
  // when execute takes the instruction or a flush kills it.
  always_comb begin
    out_valid_d     = out_valid_q;
    out_rs1_val_d   = out_rs1_val_q;
    out_rs2_val_d   = out_rs2_val_q;
    out_imm_d       = out_imm_q;
    out_rd_d        = out_rd_q;
    out_writes_rd_d = out_writes_rd_q;
    out_ctrl_d      = out_ctrl_q;
    if (accept) begin
      out_valid_d     = 1'b1;
      out_rs1_val_d   = rs1_sel;
      out_rs2_val_d   = rs2_sel;
      out_imm_d       = in_imm;
      out_rd_d        = in_rd;
      out_writes_rd_d = in_writes_rd;
      out_ctrl_d      = in_ctrl;
    end else if (out_ready || flush) begin
      out_valid_d     = 1'b0;
    end
  end

  // Output pipeline register toward execute.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q     <= 1'b0;
      out_rs1_val_q   <= '0;
      out_rs2_val_q   <= '0;
      out_imm_q       <= '0;
      out_rd_q        <= '0;
      out_writes_rd_q <= 1'b0;
      out_ctrl_q      <= '0;
    end else begin
      out_valid_q     <= out_valid_d;
      out_rs1_val_q   <= out_rs1_val_d;
      out_rs2_val_q   <= out_rs2_val_d;
      out_imm_q       <= out_imm_d;
      out_rd_q        <= out_rd_d;
      out_writes_rd_q <= out_writes_rd_d;
      out_ctrl_q      <= out_ctrl_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_rs1_val   = out_rs1_val_q;
  assign out_rs2_val   = out_rs2_val_q;
  assign out_imm       = out_imm_q;
  assign out_rd        = out_rd_q;
  assign out_writes_rd = out_writes_rd_q;
  assign out_ctrl      = out_ctrl_q;

endmodule

// File: tb/tb_operand_stage.sv
// Bench for operand_stage: directed scenarios followed by a randomized run,
// all checked every cycle against a reference model of the stage.
module tb_operand_stage;
  import operand_stage_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, flush, in_valid, in_ready;
  logic [RW-1:0]     in_rs1, in_rs2, in_rd;
  logic              in_uses_rs1, in_uses_rs2, in_writes_rd;
  logic [XLEN-1:0]   in_imm;
  logic [CTRL_W-1:0] in_ctrl;
  logic [RW-1:0]     rf_rs1, rf_rs2;
  logic [XLEN-1:0]   rf_rs1_val, rf_rs2_val;
  logic              wb_valid;
  logic [RW-1:0]     wb_rd;
  logic [XLEN-1:0]   wb_result;
  logic              out_valid, out_ready;
  logic [XLEN-1:0]   out_rs1_val, out_rs2_val, out_imm;
  logic [RW-1:0]     out_rd;
  logic              out_writes_rd;
  logic [CTRL_W-1:0] out_ctrl;
  logic [NREG-1:0]   dbg_pending_o;

  // Behavioural register file seen by the stage.
  logic [XLEN-1:0] rf_mem [NREG];
  assign rf_rs1_val = rf_mem[rf_rs1];
  assign rf_rs2_val = rf_mem[rf_rs2];

  operand_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2), .in_writes_rd(in_writes_rd),
    .in_imm(in_imm), .in_ctrl(in_ctrl),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .rf_rs1_val(rf_rs1_val), .rf_rs2_val(rf_rs2_val),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_result(wb_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_imm(out_imm),
    .out_rd(out_rd), .out_writes_rd(out_writes_rd), .out_ctrl(out_ctrl),
    .dbg_pending_o(dbg_pending_o)
  );

  // ---------------- scoreboard / model state ----------------
  typedef struct packed {
    logic [XLEN-1:0]   rs1v;
    logic [XLEN-1:0]   rs2v;
    logic [XLEN-1:0]   imm;
    logic [RW-1:0]     rd;
    logic              wr;
    logic [CTRL_W-1:0] ctrl;
  } pay_t;
  localparam int PW = $bits(pay_t);

  logic [PW-1:0] exp_q[$];      // instruction expected in the output register
  bit            m_pend [NREG]; // registers execute holds in flight
  bit            chk_en;
  bit            last_acc;
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] ref_operand(input logic [RW-1:0] idx);
    if (idx == 0) return '0;
    if (wb_valid && wb_rd == idx) return wb_result;
    return rf_mem[idx];
  endfunction

  // A register is busy if execute owns it and it is not returning now, or
  // it is the destination of the instruction waiting in the output register.
  function automatic bit ref_busy(input logic [RW-1:0] r, input bit hv, input pay_t e);
    if (r == 0) return 1'b0;
    return (m_pend[r] && !(wb_valid && wb_rd == r)) || (hv && e.wr && e.rd == r);
  endfunction

  // One clock: check the cycle's outputs at negedge, then advance the model.
  task automatic step();
    bit hv, haz, exp_ready, acc, xfer;
    pay_t e, n;
    logic [NREG-1:0] pv;
    @(negedge clk);
    hv = (exp_q.size() != 0);
    e  = hv ? pay_t'(exp_q[0]) : '0;
    haz = (in_uses_rs1  && ref_busy(in_rs1, hv, e)) ||
          (in_uses_rs2  && ref_busy(in_rs2, hv, e)) ||
          (in_writes_rd && ref_busy(in_rd,  hv, e));
    exp_ready = rst_n && !flush && !haz && (!hv || out_ready);
    for (int r = 0; r < NREG; r++) pv[r] = m_pend[r];
    if (chk_en) begin
      check("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
      check("out_valid", {31'b0, out_valid}, {31'b0, hv});
      check("rf_rs1", {28'b0, rf_rs1}, {28'b0, in_rs1});
      check("rf_rs2", {28'b0, rf_rs2}, {28'b0, in_rs2});
      check("pending", {16'b0, dbg_pending_o}, {16'b0, pv});
      if (hv) begin
        check("out_rs1_val", out_rs1_val, e.rs1v);
        check("out_rs2_val", out_rs2_val, e.rs2v);
        check("out_imm", out_imm, e.imm);
        check("out_rd", {28'b0, out_rd}, {28'b0, e.rd});
        check("out_writes_rd", {31'b0, out_writes_rd}, {31'b0, e.wr});
        check("out_ctrl", {16'b0, out_ctrl}, {16'b0, e.ctrl});
      end
    end
    acc  = in_valid && exp_ready;
    xfer = hv && out_ready;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      exp_q.delete();
      for (int r = 0; r < NREG; r++) m_pend[r] = 1'b0;
    end else begin
      if (wb_valid) m_pend[wb_rd] = 1'b0;
      if (xfer && e.wr && e.rd != 0) m_pend[e.rd] = 1'b1;
      if (acc) begin
        n.rs1v = ref_operand(in_rs1);
        n.rs2v = ref_operand(in_rs2);
        n.imm  = in_imm;
        n.rd   = in_rd;
        n.wr   = in_writes_rd;
        n.ctrl = in_ctrl;
        exp_q.delete();
        exp_q.push_back(n);
      end else if (hv && (out_ready || flush)) begin
        void'(exp_q.pop_front());
      end
    end
    if (wb_valid && wb_rd != 0) rf_mem[wb_rd] = wb_result;
    last_acc = acc;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    in_valid = 0; in_uses_rs1 = 0; in_uses_rs2 = 0; in_writes_rd = 0;
    in_rs1 = 0; in_rs2 = 0; in_rd = 0;
    wb_valid = 0; flush = 0; out_ready = 1;
  endtask

  task automatic present(input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                         input logic [RW-1:0] rd, input bit u1, input bit u2,
                         input bit wr, input logic [XLEN-1:0] imm);
    in_valid = 1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    in_uses_rs1 = u1; in_uses_rs2 = u2; in_writes_rd = wr;
    in_imm = imm; in_ctrl = CTRL_W'($urandom);
  endtask

  task automatic writeback(input logic [RW-1:0] rd, input logic [XLEN-1:0] val);
    wb_valid = 1; wb_rd = rd; wb_result = val;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    for (int r = 0; r < NREG; r++) rf_mem[r] = $urandom;
    for (int r = 0; r < NREG; r++) m_pend[r] = 1'b0;
    idle();
    in_imm = 0; in_ctrl = 0; wb_rd = 0; wb_result = 0;
    rst_n = 0; chk_en = 0;
    step();
    chk_en = 1;
    step();
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_out_imm", out_imm, 32'd0);
    check("rst_out_rs1_val", out_rs1_val, 32'd0);
    check("rst_out_ctrl", {16'b0, out_ctrl}, 32'd0);
    check("rst_pending", {16'b0, dbg_pending_o}, 32'd0);
    rst_n = 1;

    // Back-to-back independent writers x1..x5.
    for (int i = 1; i <= 5; i++) begin
      present(0, 0, RW'(i), 0, 0, 1, $urandom);
      step();
      check("stream_acc", {31'b0, last_acc}, 32'd1);
      check("stream_valid", {31'b0, out_valid}, 32'd1);
      check("stream_rd", {28'b0, out_rd}, i);
    end
    idle();
    step();
    check("stream_pending", {16'b0, dbg_pending_o}, 32'h0000_003E);
    for (int i = 1; i <= 5; i++) begin
      writeback(RW'(i), $urandom);
      step();
    end
    idle();
    step();
    check("stream_cleared", {16'b0, dbg_pending_o}, 32'd0);

    // RAW through the output register with same-cycle forwarding.
    rf_mem[3] = 32'h1111_1111;
    present(0, 0, 3, 0, 0, 1, $urandom);
    step();
    check("raw_a_acc", {31'b0, last_acc}, 32'd1);
    present(3, 0, 6, 1, 0, 1, $urandom);
    out_ready = 0;
    step();
    check("raw_stall_held", {31'b0, last_acc}, 32'd0);
    out_ready = 1;
    step();
    check("raw_stall_xfer", {31'b0, last_acc}, 32'd0);
    step();
    check("raw_stall_flight", {31'b0, last_acc}, 32'd0);
    writeback(3, 32'hDEAD_BEEF);
    step();
    check("raw_b_acc", {31'b0, last_acc}, 32'd1);
    check("raw_fwd", out_rs1_val, 32'hDEAD_BEEF);
    idle();
    step();
    writeback(6, $urandom);
    step();
    idle();

    // x0: reads zero even with a writeback to x0; rd=0 never stalls or sets.
    rf_mem[0] = 32'h1234_5678;
    present(0, 0, 0, 1, 0, 1, $urandom);
    writeback(0, 32'd5);
    step();
    check("x0_acc", {31'b0, last_acc}, 32'd1);
    check("x0_operand", out_rs1_val, 32'd0);
    wb_valid = 0;
    present(0, 0, 0, 1, 1, 1, $urandom);
    step();
    check("x0_no_stall", {31'b0, last_acc}, 32'd1);
    idle();
    step();
    check("x0_pending", {16'b0, dbg_pending_o}, 32'd0);

    // Backpressure: payload frozen, in_ready low, then same-cycle accept.
    present(0, 0, 9, 0, 0, 0, 32'hAAAA_0001);
    step();
    present(0, 0, 10, 0, 0, 0, 32'hBBBB_0002);
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
      check("bp_imm_held", out_imm, 32'hAAAA_0001);
    end
    out_ready = 1;
    step();
    check("bp_release_acc", {31'b0, last_acc}, 32'd1);
    check("bp_next_imm", out_imm, 32'hBBBB_0002);
    idle();
    step();

    // Flush kills an x7 writer; a following x7 reader goes straight in.
    rf_mem[7] = 32'h7777_0007;
    present(0, 0, 7, 0, 0, 1, $urandom);
    step();
    idle();
    out_ready = 0; flush = 1;
    step();
    check("flush_valid", {31'b0, out_valid}, 32'd0);
    check("flush_pend7", {31'b0, dbg_pending_o[7]}, 32'd0);
    flush = 0; out_ready = 1;
    present(7, 0, 11, 1, 0, 0, $urandom);
    step();
    check("flush_reader_acc", {31'b0, last_acc}, 32'd1);
    check("flush_reader_val", out_rs1_val, 32'h7777_0007);
    idle();
    step();

    // Reset in the middle of a stall on x4.
    present(0, 0, 4, 0, 0, 1, $urandom);
    step();
    idle();
    step();
    check("rst_pend4_set", {31'b0, dbg_pending_o[4]}, 32'd1);
    present(4, 0, 12, 1, 0, 0, $urandom);
    step();
    check("rst_reader_stall", {31'b0, last_acc}, 32'd0);
    rst_n = 0;
    step();
    check("rst_mid_pending", {16'b0, dbg_pending_o}, 32'd0);
    check("rst_mid_valid", {31'b0, out_valid}, 32'd0);
    rst_n = 1;
    step();
    check("rst_reader_acc", {31'b0, last_acc}, 32'd1);
    idle();
    step();

    // Randomized traffic over a small register window to provoke hazards.
    for (int c = 0; c < 600; c++) begin
      rst_n        = ($urandom_range(0, 149) != 0);
      in_valid     = $urandom_range(0, 1);
      in_rs1       = RW'($urandom_range(0, 7));
      in_rs2       = RW'($urandom_range(0, 7));
      in_rd        = RW'($urandom_range(0, 7));
      in_uses_rs1  = $urandom_range(0, 1);
      in_uses_rs2  = $urandom_range(0, 1);
      in_writes_rd = $urandom_range(0, 1);
      in_imm       = $urandom;
      in_ctrl      = CTRL_W'($urandom);
      wb_valid     = ($urandom_range(0, 2) == 0);
      wb_rd        = RW'($urandom_range(0, 7));
      wb_result    = $urandom;
      flush        = ($urandom_range(0, 19) == 0);
      out_ready    = ($urandom_range(0, 9) < 7);
      step();
    end
    rst_n = 1;
    idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
